// File: rtl/pic_8259_pkg.sv
// Shared types and helpers for the 8259A interrupt-acknowledge path.
package pic_8259_pkg;

    localparam int unsigned LEVEL_W = 3;
    localparam int unsigned IRQ_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PENDING = 3'd1,
        ST_ACK1    = 3'd2,
        ST_ACK2    = 3'd3,
        ST_ACK3    = 3'd4
    } ack_state_e;

    localparam logic [7:0] CALL_OPCODE = 8'hCD;

    // Index of the set bit; the highest set bit wins if more than one is set.
    function automatic logic [LEVEL_W-1:0] onehot_to_index(input logic [IRQ_W-1:0] onehot);
        logic [LEVEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < IRQ_W; i++) begin
            if (onehot[i]) idx = LEVEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_inta_edge_sync.sv
// INTA# synchroniser with fall/rise pulse generation.
module inta_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inta_n,
    output logic inta_sync,
    output logic fall_c,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   sync_d;
    logic [SYNC_STAGES:0]   primed;

    // primed marks when both sync and sync_d hold real pin samples, so a pin
    // already low at reset release does not look like a fresh fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain  <= '1;
            sync_d <= 1'b1;
            primed <= '0;
        end else begin
            chain  <= {chain[SYNC_STAGES-2:0], inta_n};
            sync_d <= chain[SYNC_STAGES-1];
            primed <= {primed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign inta_sync = chain[SYNC_STAGES-1];
    assign fall_c    = primed[SYNC_STAGES] & sync_d & ~inta_sync;
    assign rise_c    = primed[SYNC_STAGES] & ~sync_d & inta_sync;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259A INTA# handshake sequencer: INT pin, in-service latch, vector/CALL bytes.
// Optional automatic EOI when AUTO_EOI_EN is defined.
module interrupt_ack_sequencer
    import pic_8259_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SPURIOUS_LEVEL = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        interrupt_acknowledge_n,
    input  logic [7:0]  interrupt,
    input  logic        mode_8086,
    input  logic [4:0]  vector_base,
    input  logic [10:0] call_address,
    input  logic        call_interval_4,
    input  logic        auto_eoi,
    output logic        int_out,
    output logic        latch_in_service,
    output logic [7:0]  acknowledged,
    output logic [7:0]  end_of_interrupt,
    output logic [7:0]  clear_interrupt_request,
    output logic [7:0]  data_out,
    output logic        data_out_en
);

    ack_state_e         state, state_next;
    logic [LEVEL_W-1:0] level_q, level_next;
    logic               inta_sync, inta_fall_c, inta_rise_c;
    logic               complete_c;
    logic               int_out_next, latch_next, data_out_en_next, drive_c;
    logic [7:0]         ack_next, clear_next, data_out_next, byte_c;

    inta_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_inta_edge_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .inta_n    (interrupt_acknowledge_n),
        .inta_sync (inta_sync),
        .fall_c    (inta_fall_c),
        .rise_c    (inta_rise_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= ST_IDLE;
            level_q                 <= '0;
            int_out                 <= 1'b0;
            latch_in_service        <= 1'b0;
            acknowledged            <= '0;
            clear_interrupt_request <= '0;
            data_out                <= '0;
            data_out_en             <= 1'b0;
        end else begin
            state                   <= state_next;
            level_q                 <= level_next;
            int_out                 <= int_out_next;
            latch_in_service        <= latch_next;
            acknowledged            <= ack_next;
            clear_interrupt_request <= clear_next;
            data_out                <= data_out_next;
            data_out_en             <= data_out_en_next;
        end
    end

    // Next-state, level capture and strobes
    always_comb begin
        state_next       = state;
        level_next       = level_q;
        int_out_next     = int_out;
        latch_next       = 1'b0;
        clear_next       = '0;
        ack_next         = acknowledged;
        complete_c       = 1'b0;
        drive_c          = 1'b0;
        byte_c           = data_out;

        case (state)
            ST_IDLE: begin
                if (|interrupt) begin
                    state_next   = ST_PENDING;
                    int_out_next = 1'b1;
                end
            end
            ST_PENDING: begin
                if (inta_fall_c) begin
                    state_next = ST_ACK1;
                    if (|interrupt) begin
                        level_next = onehot_to_index(interrupt);
                        latch_next = 1'b1;
                        clear_next = 8'd1 << level_next;
                        ack_next   = 8'd1 << level_next;
                    end else begin
                        level_next = LEVEL_W'(SPURIOUS_LEVEL);
                        ack_next   = '0;
                    end
                end
            end
            ST_ACK1: begin
                if (inta_fall_c) begin
                    state_next   = ST_ACK2;
                    int_out_next = 1'b0;
                end
            end
            ST_ACK2: begin
                if (mode_8086) begin
                    complete_c = inta_rise_c;
                end else if (inta_fall_c) begin
                    state_next = ST_ACK3;
                end
            end
            ST_ACK3: begin
                complete_c = inta_rise_c;
            end
            default: state_next = ST_IDLE;
        endcase

        // A request present at completion goes straight back to PENDING.
        if (complete_c) begin
            state_next   = (|interrupt) ? ST_PENDING : ST_IDLE;
            int_out_next = |interrupt;
        end

        case (state_next)
            ST_ACK1: begin
                drive_c = ~mode_8086;
                byte_c  = CALL_OPCODE;
            end
            ST_ACK2: begin
                drive_c = 1'b1;
                if (mode_8086)            byte_c = {vector_base, level_next};
                else if (call_interval_4) byte_c = {call_address[2:0], level_next, 2'b00};
                else                      byte_c = {call_address[1:0], level_next, 3'b000};
            end
            ST_ACK3: begin
                drive_c = 1'b1;
                byte_c  = call_address[10:3];
            end
            default: begin
                drive_c = 1'b0;
                byte_c  = data_out;
            end
        endcase

        // Bus is driven only while synchronised INTA# is low; the byte holds afterwards.
        data_out_en_next = drive_c & ~inta_sync;
        data_out_next    = data_out_en_next ? byte_c : data_out;
    end

`ifdef AUTO_EOI_EN
    logic [7:0] eoi_next;

    // acknowledged is 0 for a spurious level, so no AEOI is produced for it.
    assign eoi_next = (complete_c && auto_eoi) ? acknowledged : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) end_of_interrupt <= '0;
        else        end_of_interrupt <= eoi_next;
    end
`else
    logic unused_auto_eoi;

    assign unused_auto_eoi  = auto_eoi;
    assign end_of_interrupt = '0;
`endif

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Scoreboard bench for interrupt_ack_sequencer (8086, 8080, spurious, AEOI, reset, idle pulses).
module tb_interrupt_ack_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inta_n = 1'b1;
    logic [7:0]  interrupt = '0;
    logic        mode_8086 = 1'b1;
    logic [4:0]  vector_base = '0;
    logic [10:0] call_address = '0;
    logic        call_interval_4 = 1'b1;
    logic        auto_eoi = 1'b0;
    logic        int_out, latch_in_service, data_out_en;
    logic [7:0]  acknowledged, end_of_interrupt, clear_interrupt_request, data_out;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned idle_hits = 0;

    logic [7:0] exp_bus[$];
    logic [7:0] exp_ack[$];
    logic [7:0] exp_eoi[$];
    logic [7:0] exp_val;
    logic       prev_en = 1'b0;
    logic       prev_latch = 1'b0;

    interrupt_ack_sequencer #(
        .SYNC_STAGES    (2),
        .SPURIOUS_LEVEL (7)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .interrupt_acknowledge_n (inta_n),
        .interrupt               (interrupt),
        .mode_8086               (mode_8086),
        .vector_base             (vector_base),
        .call_address            (call_address),
        .call_interval_4         (call_interval_4),
        .auto_eoi                (auto_eoi),
        .int_out                 (int_out),
        .latch_in_service        (latch_in_service),
        .acknowledged            (acknowledged),
        .end_of_interrupt        (end_of_interrupt),
        .clear_interrupt_request (clear_interrupt_request),
        .data_out                (data_out),
        .data_out_en             (data_out_en)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic inta_pulse(input int low_cyc, input int high_cyc);
        @(posedge clk);
        #1 inta_n = 1'b0;
        repeat (low_cyc) @(posedge clk);
        #1 inta_n = 1'b1;
        repeat (high_cyc) @(posedge clk);
    endtask

    // Scoreboard: pop expected bytes/levels as the DUT produces them.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en    = 1'b0;
            prev_latch = 1'b0;
        end else begin
            if (data_out_en && !prev_en) begin
                if (exp_bus.size() == 0) check_value("bus_extra", 32'(data_out_en), 32'd0);
                else check_value("bus_byte", 32'(data_out), 32'(exp_bus.pop_front()));
            end
            if (latch_in_service) begin
                check_value("latch_width", 32'(prev_latch), 32'd0);
                if (exp_ack.size() == 0) begin
                    check_value("latch_extra", 32'(latch_in_service), 32'd0);
                end else begin
                    exp_val = exp_ack.pop_front();
                    check_value("acknowledged", 32'(acknowledged), 32'(exp_val));
                    check_value("clear_irr", 32'(clear_interrupt_request), 32'(exp_val));
                end
            end
            if (|end_of_interrupt) begin
                if (exp_eoi.size() == 0) check_value("eoi_extra", 32'(end_of_interrupt), 32'd0);
                else check_value("eoi", 32'(end_of_interrupt), 32'(exp_eoi.pop_front()));
            end
            prev_en    = data_out_en;
            prev_latch = latch_in_service;
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_value("rst_int", 32'(int_out), 32'd0);
        check_value("rst_en", 32'(data_out_en), 32'd0);
        check_value("rst_ack", 32'(acknowledged), 32'd0);
        check_value("rst_data", 32'(data_out), 32'd0);
        rst_n = 1'b1;

        // 1: 8086 cycle, level 2
        mode_8086 = 1'b1; vector_base = 5'h08; interrupt = 8'h04;
        exp_ack.push_back(8'h04); exp_bus.push_back(8'h42);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("t1_int_before", 32'(int_out), 32'd1);
        @(posedge clk);
        #1 inta_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("t1_latch_latency", 32'(latch_in_service), 32'd1);
        check_value("t1_ack1_en", 32'(data_out_en), 32'd0);
        repeat (3) @(posedge clk);
        #1 inta_n = 1'b1; interrupt = 8'h00;
        repeat (6) @(posedge clk);
        #1 inta_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_value("t1_int_cleared", 32'(int_out), 32'd0);
        check_value("t1_ack2_en", 32'(data_out_en), 32'd1);
        @(posedge clk);
        #1 inta_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_value("t1_en_drop", 32'(data_out_en), 32'd0);
        check_value("t1_data_hold", 32'(data_out), 32'h42);
        check_value("t1_ack_hold", 32'(acknowledged), 32'h04);

        // 2: 8080 CALL, interval 4, level 3
        mode_8086 = 1'b0; call_interval_4 = 1'b1; call_address = 11'h123; interrupt = 8'h08;
        exp_ack.push_back(8'h08);
        exp_bus.push_back(8'hCD); exp_bus.push_back(8'h6C); exp_bus.push_back(8'h24);
        repeat (3) @(posedge clk);
        inta_pulse(6, 6);
        interrupt = 8'h00;
        inta_pulse(6, 6);
        inta_pulse(6, 6);
        @(negedge clk);
        check_value("t2_int_after", 32'(int_out), 32'd0);
        check_value("t2_en_after", 32'(data_out_en), 32'd0);

        // 2b: 8080 CALL, interval 8, level 5
        call_interval_4 = 1'b0; interrupt = 8'h20;
        exp_ack.push_back(8'h20);
        exp_bus.push_back(8'hCD); exp_bus.push_back(8'hE8); exp_bus.push_back(8'h24);
        repeat (3) @(posedge clk);
        inta_pulse(6, 6);
        interrupt = 8'h00;
        inta_pulse(6, 6);
        inta_pulse(6, 6);

        // 3: spurious request, 8086
        mode_8086 = 1'b1; vector_base = 5'h08; interrupt = 8'h02;
        exp_bus.push_back(8'h47);
        repeat (3) @(posedge clk);
        interrupt = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("t3_int_held", 32'(int_out), 32'd1);
        inta_pulse(6, 6);
        inta_pulse(6, 6);
        @(negedge clk);
        check_value("t3_ack_zero", 32'(acknowledged), 32'd0);

        // 4: automatic EOI on level 7
        auto_eoi = 1'b1; interrupt = 8'h80;
        exp_ack.push_back(8'h80); exp_bus.push_back(8'h47);
`ifdef AUTO_EOI_EN
        exp_eoi.push_back(8'h80);
`endif
        repeat (3) @(posedge clk);
        inta_pulse(6, 6);
        interrupt = 8'h00;
        inta_pulse(6, 6);
        auto_eoi = 1'b0;

        // 5: reset during ACK2 with INTA# still low
        interrupt = 8'h04;
        exp_ack.push_back(8'h04); exp_bus.push_back(8'h42);
        repeat (3) @(posedge clk);
        inta_pulse(6, 6);
        @(posedge clk);
        #1 inta_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_value("t5_in_ack2", 32'(data_out_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check_value("t5_rst_int", 32'(int_out), 32'd0);
        check_value("t5_rst_en", 32'(data_out_en), 32'd0);
        check_value("t5_rst_data", 32'(data_out), 32'd0);
        check_value("t5_rst_ack", 32'(acknowledged), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 inta_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_value("t5_pending_int", 32'(int_out), 32'd1);
        check_value("t5_no_drive", 32'(data_out_en), 32'd0);
        check_value("t5_no_capture", 32'(acknowledged), 32'd0);
        // A fresh cycle completes normally after the reset
        exp_ack.push_back(8'h04); exp_bus.push_back(8'h42);
        inta_pulse(6, 6);
        interrupt = 8'h00;
        inta_pulse(6, 6);

        // 6: INTA# pulses in IDLE are ignored
        for (int p = 0; p < 2; p++) begin
            @(posedge clk);
            #1 inta_n = 1'b0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (int_out || data_out_en || latch_in_service) idle_hits++;
                if (c == 5) inta_n = 1'b1;
            end
        end
        check_value("t6_idle_quiet", idle_hits, 32'd0);

        // Every expected event was produced
        repeat (4) @(posedge clk);
        check_value("bus_left", 32'(exp_bus.size()), 32'd0);
        check_value("ack_left", 32'(exp_ack.size()), 32'd0);
        check_value("eoi_left", 32'(exp_eoi.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
